// File: rtl/prog_seq.sv
// -----------------------------------------------------------------------------
// prog_seq -- program-memory sequencer
//
// Owns the mode/address/write-data pins of a 32-byte program memory
// (byte-addressed, 32-bit words stored little-endian, combinational write while
// mem_p=1, combinational read while mem_p=0). It has two jobs:
//   * load: accept a program word-by-word from a host stream and write it
//     to consecutive word addresses starting at 0;
//   * fetch: read instructions back and present them to the CPU front end.
//
// Handshake semantics (host load port and CPU fetch port alike): a transfer
// happens on a rising clk edge where valid && ready are both 1. The producer
// holds valid and its data stable until that edge; ready may change freely.
//
// Optional feature: define PROG_SEQ_CHECKSUM_EN to add an XOR checksum of the
// loaded words (ld_csum) and a comparison flag against exp_csum (csum_ok).
//
// Ports:
//   clk, rst_n       rising-edge clock, synchronous active-low reset
//   load_req         pulse: start a program load (honoured only in IDLE)
//   run_req          pulse: start fetching at address 0 (IDLE, after a load)
//   halt_req         pulse: abandon fetching, drop the in-flight instruction
//   ld_valid/ld_ready/ld_data/ld_last   host word stream
//   mem_p/mem_add/mem_inst/mem_prog     program memory pins
//   fetch_valid/fetch_ready/fetch_inst/fetch_pc   instruction port to the CPU
//   jmp_valid/jmp_addr  redirect target, sampled on a fetch handshake
//   loaded           a complete load has finished since reset
//   busy             sequencer is not IDLE
//   ld_csum, exp_csum, csum_ok   (PROG_SEQ_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module prog_seq #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NWORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              mem_p,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_inst,
    input  logic [DATA_W-1:0] mem_prog,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [DATA_W-1:0] fetch_inst,
    output logic [ADDR_W-1:0] fetch_pc,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              loaded,
`ifdef PROG_SEQ_CHECKSUM_EN
    output logic [DATA_W-1:0] ld_csum,
    input  logic [DATA_W-1:0] exp_csum,
    output logic              csum_ok,
`endif
    output logic              busy
);

    // Word step in bytes, address of the final word, and the mask that
    // word-aligns a redirect target.
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((NWORDS - 1) * 4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_FETCH   = 3'd3,
        S_CAPTURE = 3'd4,
        S_VALID   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              last_q, last_d;

    // Next values of the registered outputs.
    logic              mem_p_d;
    logic [ADDR_W-1:0] mem_add_d;
    logic [DATA_W-1:0] mem_inst_d;
    logic              ld_ready_d;
    logic              fetch_valid_d;
    logic [DATA_W-1:0] fetch_inst_d;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic              loaded_d;
    logic              busy_d;

    logic              ld_fire;
    logic              fetch_fire;

    assign ld_fire    = ld_valid && ld_ready;
    assign fetch_fire = fetch_valid && fetch_ready;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        pc_d          = pc_q;
        last_d        = last_q;
        mem_p_d       = 1'b0;
        mem_add_d     = mem_add;
        mem_inst_d    = mem_inst;
        ld_ready_d    = 1'b0;
        fetch_valid_d = fetch_valid;
        fetch_inst_d  = fetch_inst;
        fetch_pc_d    = fetch_pc;
        loaded_d      = loaded;

        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d    = S_LOAD;
                    wptr_d     = '0;
                    loaded_d   = 1'b0;
                    ld_ready_d = 1'b1;
                end else if (run_req && loaded) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    mem_add_d = '0;
                end
            end

            S_LOAD: begin
                ld_ready_d = 1'b1;
                if (ld_fire) begin
                    // Address and data are registered on the same edge that
                    // raises mem_p, so both are stable for the whole write.
                    state_d    = S_WRITE;
                    mem_inst_d = ld_data;
                    mem_add_d  = wptr_q;
                    mem_p_d    = 1'b1;
                    ld_ready_d = 1'b0;
                    // The top word always ends the load so wptr never wraps.
                    last_d     = ld_last || (wptr_q == LAST_ADDR);
                end
            end

            S_WRITE: begin
                wptr_d = wptr_q + WORD_STEP;
                if (last_q) begin
                    state_d  = S_IDLE;
                    loaded_d = 1'b1;
                end else begin
                    state_d    = S_LOAD;
                    ld_ready_d = 1'b1;
                end
            end

            S_FETCH: begin
                // mem_add already equals pc; give the read one full cycle.
                if (halt_req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (halt_req) begin
                    state_d = S_IDLE;
                end else begin
                    state_d       = S_VALID;
                    fetch_inst_d  = mem_prog;
                    fetch_pc_d    = pc_q;
                    fetch_valid_d = 1'b1;
                end
            end

            S_VALID: begin
                // halt outranks a same-cycle handshake: the word is dropped
                // and pc stays put.
                if (halt_req) begin
                    state_d       = S_IDLE;
                    fetch_valid_d = 1'b0;
                end else if (fetch_fire) begin
                    state_d       = S_FETCH;
                    fetch_valid_d = 1'b0;
                    pc_d          = jmp_valid ? (jmp_addr & ALIGN_MASK)
                                              : (pc_q + WORD_STEP);
                    mem_add_d     = pc_d;
                end
            end

            default: begin
                state_d       = S_IDLE;
                fetch_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            pc_q        <= '0;
            last_q      <= 1'b0;
            mem_p       <= 1'b0;
            mem_add     <= '0;
            mem_inst    <= '0;
            ld_ready    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_inst  <= '0;
            fetch_pc    <= '0;
            loaded      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            pc_q        <= pc_d;
            last_q      <= last_d;
            mem_p       <= mem_p_d;
            mem_add     <= mem_add_d;
            mem_inst    <= mem_inst_d;
            ld_ready    <= ld_ready_d;
            fetch_valid <= fetch_valid_d;
            fetch_inst  <= fetch_inst_d;
            fetch_pc    <= fetch_pc_d;
            loaded      <= loaded_d;
            busy        <= busy_d;
        end
    end

`ifdef PROG_SEQ_CHECKSUM_EN
    // -------------------------------------------------------------------------
    // XOR checksum of the words accepted during the current load
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_csum <= '0;
            csum_ok <= 1'b0;
        end else begin
            if (state_q == S_IDLE && load_req) begin
                ld_csum <= '0;
            end else if (state_q == S_LOAD && ld_fire) begin
                ld_csum <= ld_csum ^ ld_data;
            end
            csum_ok <= loaded && (ld_csum == exp_csum);
        end
    end
`endif

endmodule

// File: tb/tb_prog_seq.sv
// -----------------------------------------------------------------------------
// tb_prog_seq -- directed self-checking bench for prog_seq
//
// Models the 32-byte little-endian program memory, loads programs through the
// host stream, fetches them back and compares every observation against
// values kept by the bench (the image it loaded and hand-computed constants).
// -----------------------------------------------------------------------------
module tb_prog_seq;

    // ---------------------------------------------------------------- clock/reset
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic        load_req, run_req, halt_req;
    logic        ld_valid, ld_ready, ld_last;
    logic [31:0] ld_data;
    logic        mem_p;
    logic [4:0]  mem_add;
    logic [31:0] mem_inst, mem_prog;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_inst;
    logic [4:0]  fetch_pc;
    logic        jmp_valid;
    logic [4:0]  jmp_addr;
    logic        loaded, busy;
`ifdef PROG_SEQ_CHECKSUM_EN
    logic [31:0] ld_csum, exp_csum;
    logic        csum_ok;
`endif

    prog_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_req   (load_req),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .mem_p      (mem_p),
        .mem_add    (mem_add),
        .mem_inst   (mem_inst),
        .mem_prog   (mem_prog),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_inst (fetch_inst),
        .fetch_pc   (fetch_pc),
        .jmp_valid  (jmp_valid),
        .jmp_addr   (jmp_addr),
        .loaded     (loaded),
`ifdef PROG_SEQ_CHECKSUM_EN
        .ld_csum    (ld_csum),
        .exp_csum   (exp_csum),
        .csum_ok    (csum_ok),
`endif
        .busy       (busy)
    );

    // ---------------------------------------------------------------- memory model
    // mem_p is held for a whole cycle with stable address/data, so a mid-cycle
    // sample captures the level-sensitive write.
    logic [7:0] mem [0:31];
    always @(negedge clk) begin
        if (mem_p === 1'b1) begin
            mem[mem_add]        <= mem_inst[7:0];
            mem[mem_add + 5'd1] <= mem_inst[15:8];
            mem[mem_add + 5'd2] <= mem_inst[23:16];
            mem[mem_add + 5'd3] <= mem_inst[31:24];
        end
    end
    assign mem_prog = {mem[mem_add + 5'd3], mem[mem_add + 5'd2],
                       mem[mem_add + 5'd1], mem[mem_add]};

    // ---------------------------------------------------------------- scoreboard
    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] src [0:7];
    logic [31:0] img [0:7];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("%s", tag);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams src[0..n-1] with ld_valid held high; records each memory write
    // into img and checks address, data and single-cycle mem_p pulses.
    task automatic load_stream(input int n, input bit use_last,
                               output int cycles, output int pulses);
        int          idx;
        logic        prev;
        logic [31:0] exp_word;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(src[i]);
        idx      = 0;
        prev     = 1'b0;
        cycles   = 0;
        pulses   = 0;
        ld_valid = 1'b1;
        ld_data  = src[0];
        ld_last  = use_last && (n == 1);
        while (cycles < 40) begin
            tick();
            cycles++;
            if (mem_p === 1'b1) begin
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check("mem_p_width", 32'(prev), 32'd0);
                check("wr_addr", 32'(mem_add), 32'(pulses * 4));
                check("wr_data", mem_inst, exp_word);
                if (pulses < 8) img[pulses] = exp_word;
                pulses++;
                idx++;
                if (idx < n) begin
                    ld_data = src[idx];
                    ld_last = use_last && (idx == n - 1);
                end
            end
            prev = mem_p;
            if (busy !== 1'b1) break;
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (fetch_valid !== 1'b1 && lat < 20);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int cyc, pul, lat, exp_pc;

        rst_n = 1'b0;
        load_req = 1'b0; run_req = 1'b0; halt_req = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        fetch_ready = 1'b0; jmp_valid = 1'b0; jmp_addr = '0;
`ifdef PROG_SEQ_CHECKSUM_EN
        exp_csum = '0;
`endif
        tick();
        tick();

        // Reset state
        check("rst_mem_p",       32'(mem_p),       32'd0);
        check("rst_mem_add",     32'(mem_add),     32'd0);
        check("rst_mem_inst",    mem_inst,         32'd0);
        check("rst_ld_ready",    32'(ld_ready),    32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_inst",  fetch_inst,       32'd0);
        check("rst_fetch_pc",    32'(fetch_pc),    32'd0);
        check("rst_loaded",      32'(loaded),      32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        rst_n = 1'b1;
        tick();

        // run_req before any load is ignored
        run_req = 1'b1; tick(); run_req = 1'b0;
        check("run_unloaded_busy", 32'(busy), 32'd0);
        tick();
        check("run_unloaded_busy2", 32'(busy), 32'd0);
        check("run_unloaded_fv",    32'(fetch_valid), 32'd0);

        // Full 8-word load, ends on the address-28 word without ld_last
        for (int i = 0; i < 8; i++) src[i] = 32'h1111_1111 * i;
        load_req = 1'b1; tick(); load_req = 1'b0;
        check("load_ld_ready", 32'(ld_ready), 32'd1);
        check("load_busy",     32'(busy),     32'd1);
        check("load_loaded",   32'(loaded),   32'd0);
        load_stream(8, 1'b0, cyc, pul);
        check("full_cycles",   32'(cyc),      32'd16);
        check("full_pulses",   32'(pul),      32'd8);
        check("full_loaded",   32'(loaded),   32'd1);
        check("full_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        check("full_no_extra_write", 32'(mem_p),    32'd0);
        check("full_still_idle",     32'(busy),     32'd0);
        ld_valid = 1'b0;

        // Short 3-word load terminated by ld_last
        src[0] = 32'hDEAD_BEEF; src[1] = 32'hCAFE_F00D; src[2] = 32'h1234_5678;
        load_req = 1'b1; tick(); load_req = 1'b0;
        load_stream(3, 1'b1, cyc, pul);
        ld_valid = 1'b0; ld_last = 1'b0;
        check("short_cycles", 32'(cyc),    32'd6);
        check("short_pulses", 32'(pul),    32'd3);
        check("short_loaded", 32'(loaded), 32'd1);

        // Fetch sweep 0,4,...,28,0 with fetch_ready high
        fetch_ready = 1'b1;
        run_req = 1'b1; tick(); run_req = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        for (int n = 0; n < 9; n++) begin
            exp_pc = (n * 4) % 32;
            if (n == 8) fetch_ready = 1'b0;
            wait_valid(lat);
            check("sweep_latency", 32'(lat),      32'd2);
            check("sweep_pc",      32'(fetch_pc), 32'(exp_pc));
            check("sweep_inst",    fetch_inst,    img[exp_pc / 4]);
            if (n < 8) tick();
        end

        // Back-pressure: 5 stall cycles, then exactly one step of 4
        for (int s = 0; s < 5; s++) begin
            tick();
            check("stall_fv",   32'(fetch_valid), 32'd1);
            check("stall_pc",   32'(fetch_pc),    32'd0);
            check("stall_inst", fetch_inst,       img[0]);
        end
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
        check("hs_drop_fv", 32'(fetch_valid), 32'd0);
        wait_valid(lat);
        check("step_latency", 32'(lat),      32'd2);
        check("step_pc",      32'(fetch_pc), 32'd4);
        check("step_inst",    fetch_inst,    img[1]);

        // load_req outside IDLE is ignored
        load_req = 1'b1; tick(); load_req = 1'b0;
        check("ign_load_fv",     32'(fetch_valid), 32'd1);
        check("ign_load_loaded", 32'(loaded),      32'd1);
        check("ign_load_pc",     32'(fetch_pc),    32'd4);
        check("ign_load_ready",  32'(ld_ready),    32'd0);

        // Redirect to 22 lands on word 20
        fetch_ready = 1'b1; jmp_valid = 1'b1; jmp_addr = 5'd22;
        tick();
        fetch_ready = 1'b0; jmp_valid = 1'b0; jmp_addr = 5'd0;
        wait_valid(lat);
        check("jmp_pc",   32'(fetch_pc), 32'd20);
        check("jmp_inst", fetch_inst,    img[5]);

        // halt beats a same-cycle handshake
        fetch_ready = 1'b1; halt_req = 1'b1; tick();
        halt_req = 1'b0; fetch_ready = 1'b0;
        check("halt_busy", 32'(busy),        32'd0);
        check("halt_fv",   32'(fetch_valid), 32'd0);
        check("halt_pc",   32'(fetch_pc),    32'd20);
        tick();
        check("halt_stays_idle", 32'(busy), 32'd0);

        // run_req restarts at 0
        run_req = 1'b1; tick(); run_req = 1'b0;
        wait_valid(lat);
        check("restart_latency", 32'(lat),      32'd2);
        check("restart_pc",      32'(fetch_pc), 32'd0);
        check("restart_inst",    fetch_inst,    img[0]);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        check("halt2_busy", 32'(busy), 32'd0);

`ifdef PROG_SEQ_CHECKSUM_EN
        // Checksum of two words
        src[0] = 32'hA5A5_A5A5; src[1] = 32'h0F0F_0F0F;
        load_req = 1'b1; tick(); load_req = 1'b0;
        check("csum_cleared", ld_csum, 32'd0);
        load_stream(2, 1'b1, cyc, pul);
        ld_valid = 1'b0; ld_last = 1'b0;
        check("csum_value", ld_csum, 32'hAAAA_AAAA);
        exp_csum = 32'hAAAA_AAAA; tick();
        check("csum_ok_match", 32'(csum_ok), 32'd1);
        exp_csum = 32'h0; tick();
        check("csum_ok_diff", 32'(csum_ok), 32'd0);
`endif

        // Reset in the middle of a write
        load_req = 1'b1; tick(); load_req = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h5A5A_5A5A; tick();
        check("midload_in_write", 32'(mem_p), 32'd1);
        rst_n = 1'b0; tick(); rst_n = 1'b1; ld_valid = 1'b0;
        check("midrst_mem_p",    32'(mem_p),    32'd0);
        check("midrst_loaded",   32'(loaded),   32'd0);
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_ld_ready", 32'(ld_ready), 32'd0);

        // Not loaded any more, so run_req is ignored again
        run_req = 1'b1; tick(); run_req = 1'b0;
        check("post_rst_run_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_seq.md
Name: prog_seq

Overview:
- Sequencer that owns the 32-byte program memory (five-bit byte address, 32-bit words stored as four bytes little-endian, combinational write while its program-mode pin is high, combinational read while low).
- Two jobs: load a program word-by-word from a host stream, then fetch instructions for the CPU over a valid/ready port.
- Only block that drives the memory's mode, address and write-data pins; sits between the host/loader and the CPU front end.

Parameters:
- ADDR_W, 5, memory byte-address width; memory holds 2**ADDR_W bytes.
- DATA_W, 32, instruction width; fixed at 4 bytes per word.
- NWORDS, 8, words per program; equals 2**ADDR_W/4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset; one clock, synchronous reset, active-low.
- load_req  in  1  one-cycle pulse: start program load.
- run_req  in  1  one-cycle pulse: start fetching from address 0.
- halt_req  in  1  one-cycle pulse: stop fetching.
- ld_valid  in  1  host word valid.
- ld_ready  out  1  sequencer accepts host word.
- ld_data  in  32  host word.
- ld_last  in  1  marks final host word; qualified by ld_valid.
- mem_p  out  1  memory program mode (1 = write).
- mem_add  out  5  memory byte address.
- mem_inst  out  32  memory write data.
- mem_prog  in  32  memory read data.
- fetch_valid  out  1  instruction valid to CPU.
- fetch_ready  in  1  CPU accepts instruction.
- fetch_inst  out  32  registered instruction.
- fetch_pc  out  5  byte address of fetch_inst.
- jmp_valid  in  1  redirect; sampled only on a fetch handshake.
- jmp_addr  in  5  redirect target; bits [1:0] forced to 0.
- loaded  out  1  a complete load has finished since reset.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0, including mem_p, mem_add, mem_inst, ld_ready, fetch_valid, fetch_inst, fetch_pc, loaded, busy; internal wptr=0, pc=0.
- All outputs are registered. mem_p is only ever 1 while mem_add and mem_inst are stable.
- IDLE:
  - load_req -> LOAD, wptr=0, loaded cleared.
  - Else run_req with loaded=1 -> FETCH, pc=0.
  - run_req with loaded=0 is ignored.
  - load_req and run_req in the same cycle: load wins.
- LOAD:
  - ld_ready=1, mem_p=0.
  - On ld_valid&&ld_ready: capture ld_data into mem_inst, mem_add=wptr, remember last = ld_last || (wptr==28) -> WRITE.
- WRITE (1 cycle):
  - mem_p=1, ld_ready=0.
  - Next edge: mem_p=0, wptr+=4.
  - If last: -> IDLE, loaded=1. Else -> LOAD.
  - Throughput: 1 word per 2 cycles.
- Full boundary: the word at address 28 always ends the load. wptr never wraps during load. Further host words are not accepted (ld_ready=0).
- FETCH (1 cycle): mem_p=0, mem_add=pc -> CAPTURE.
- CAPTURE: next edge latches fetch_inst=mem_prog, fetch_pc=pc, fetch_valid=1 -> VALID. Latency from pc update to fetch_valid is 2 cycles.
- VALID:
  - fetch_inst and fetch_pc hold while fetch_ready=0.
  - On fetch_valid&&fetch_ready: fetch_valid=0; pc = jmp_valid ? {jmp_addr[4:2],2'b00} : pc+4 mod 32 (28 wraps to 0) -> FETCH.
- halt_req in FETCH/CAPTURE/VALID: next edge -> IDLE, fetch_valid=0. The instruction in flight is dropped, not delivered. halt_req has priority over a same-cycle handshake.
- load_req outside IDLE is ignored. run_req outside IDLE is ignored.
- Reset mid-load: memory contents are unspecified, loaded=0, mem_p drops the same edge.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: PROG_SEQ_CHECKSUM_EN.
- Defined:
  - Adds output ld_csum (32 bits), cleared to 0 on reset and on load_req acceptance.
  - XOR-accumulates each accepted ld_data at the LOAD handshake.
  - Adds output csum_ok (1 bit), registered; equals 1 when loaded=1 and ld_csum matches input exp_csum (32 bits). Reset 0.
- Undefined: the ports ld_csum, exp_csum and csum_ok do not exist and no accumulator logic is built.

Test Plan:
- Reset then load_req; stream 8 words 0x00000000, 0x11111111, …, 0x77777777 with ld_valid held high -> mem_p pulses at addresses 0, 4, …, 28, each for exactly 1 cycle; loaded=1 after the 8th WRITE; 16 cycles from first accept to IDLE.
- Load 3 words with ld_last on the 3rd, then run_req with fetch_ready=1 -> fetch_pc sequence 0, 4, 8, 12, …, 28, 0. fetch_inst matches the loaded words for pc 0, 4, 8. fetch_valid rises 2 cycles after each pc update.
- During fetch, hold fetch_ready=0 for 5 cycles -> fetch_valid, fetch_inst and fetch_pc stay stable; a single handshake advances pc by exactly 4.
- Handshake with jmp_valid=1, jmp_addr=5'd22 -> next fetch_pc=20.
- halt_req together with fetch_ready=1 in VALID -> IDLE next edge, fetch_valid=0, pc not advanced. Then run_req -> fetch restarts at pc=0. run_req before any load -> stays IDLE.
- Checksum build (PROG_SEQ_CHECKSUM_EN defined): load 0xA5A5A5A5 and 0x0F0F0F0F with ld_last on the 2nd -> ld_csum=0xAAAAAAAA; csum_ok=1 with exp_csum=0xAAAAAAAA, csum_ok=0 with exp_csum=0.
